lif_neuron_pool: RTL and testbench
==================================

Name: lif_neuron_pool

Overview:
- Time-multiplexed leaky integrate-and-fire population of N_NEURONS neurons.
- Sits directly downstream of the synapse stage: consumes the per-slot synaptic current (each_I, scale 1024 = 1.0) and produces one spike decision per neuron per population pass.
- Membrane and refractory state live in an internal slot-indexed state memory.
- The slot sequencer matches the synapse stage's 2-cycle slot, so both blocks walk the same neuron_index.

Parameters:
- N_NEURONS, 128: neurons per population; power of two; index width = log2(N_NEURONS).
- V_THRESH, 10240: signed 32-bit firing threshold (10.0 at scale 1024).
- V_RESET, 0: signed 32-bit post-spike and initial membrane value.
- LEAK_SHIFT, 3: leak term is v >>> LEAK_SHIFT per pass.
- REFRACT, 2: passes held at V_RESET after a spike (0..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- I_in  in  32  signed synaptic current for the current slot_index; sampled at the rising edge ending phase 1.
- slot_index  out  7  neuron index currently being processed.
- phase  out  1  0 = read phase, 1 = compute/write phase.
- spike_out  out  1  one-cycle pulse: neuron spike_index fired.
- spike_index  out  7  index associated with spike_out.
- v_mon  out  32  signed membrane value of neuron 0, updated once per pass.
- spike_count  out  8  number of spikes in the last completed pass.
- frame_done  out  1  one-cycle pulse at the end of each pass.

Behaviour:
- Reset values: slot_index=0, phase=0, spike_out=0, spike_index=0, v_mon=0, spike_count=0, frame_done=0, first_pass=1, internal pass counter=0.
- Sequencer:
  - phase toggles every clk; a slot is 2 cycles.
  - slot_index increments on the edge leaving phase 1 and wraps from N_NEURONS-1 to 0.
  - The first edge after reset deasserts it into phase 1 of slot 0? No: phase 0 of slot 0 is the first cycle after reset deassertion.
- Phase 0: read v[idx] and refr[idx] from state memory; the registered read is valid at the end of phase 0.
- Phase 1, combinational compute, written at the edge ending phase 1:
  - If first_pass: v_src=V_RESET, r_src=0; otherwise the stored values.
  - sum = v_src - (v_src >>> LEAK_SHIFT) + I_in, evaluated at 34 bits.
  - Saturate sum to the signed 32-bit range [0x80000000, 0x7FFFFFFF].
  - If r_src != 0: v_next=V_RESET, r_next=r_src-1, no spike.
  - Else if sat_sum >= V_THRESH (signed compare): spike, v_next=V_RESET, r_next=REFRACT.
  - Else: v_next=sat_sum, r_next=0.
- Outputs, registered on the edge ending phase 1:
  - spike_out=spike and spike_index=idx; spike_out is high for exactly one cycle, the following phase 0, and is 0 otherwise.
  - When idx==0: v_mon=v_next.
- Pass end, when idx==N_NEURONS-1 at the edge ending phase 1:
  - frame_done=1 for one cycle.
  - spike_count=running count including this slot's spike.
  - Running count clears to 0; first_pass clears to 0.
- Running count saturates at 255; it cannot exceed 128 with the default.
- Simultaneous spike at the last slot and frame_done: both assert in the same cycle, and the spike is included in spike_count.
- Reset mid-pass:
  - Immediate asynchronous clear of all registers; the sequence restarts at slot 0, phase 0.
  - first_pass=1, so stale state-memory contents are ignored and overwritten.
- I_in is not registered by this block beyond the phase-1 sample; upstream must hold it stable across phase 1 for the slot shown on slot_index.

Decomposition:
- Shared package (neuron_pkg):
  - IDX_W;
  - the 32-bit signed state type;
  - the current-scale constant 1024;
  - a saturating-add function, also reused by other population stages.
- One sub-module, neuron_state_ram:
  - single-port, N_NEURONS x 36 bits (32 v + 4 refr), synchronous read, synchronous write with write enable;
  - inferred array, no reset on contents.

Test Plan:
- I_in=0 constant for 4 passes -> no spike_out; v_mon=0; spike_count=0; frame_done every 256 cycles.
- I_in=2048 to all slots, default parameters -> v_mon sequence 2048, 3840, 5408, 6780, 7981, 9032, 9951; 8th pass spikes (sum 10756), so spike_count=128 and v_mon=0 that pass.
- Continue the above with REFRACT=2 -> passes 9 and 10 have v_mon=0 and spike_count=0; integration resumes on pass 11 (v_mon=2048); pass 18 spikes again.
- I_in=0x7FFFFFFF on slot 5 only, V_THRESH=0x7FFFFFFF -> saturated sum, no wrap to negative. Spike at slot 5 on pass 1 (spike_index=5, spike_out one cycle); spike_count=1.
- I_in=0x80000000 on slot 0 with V_RESET=0 -> v_mon=0x80000000 (saturated low), no spike, no wrap.
- Assert reset at slot 60 of pass 3 mid-ramp -> outputs 0 immediately. After release, slot_index=0, phase=0, and first_pass=1 ignores old membrane values: pass 1 v_mon=2048 again.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the spiking population stages.
// Provides index width, membrane state type, current scale and saturating add.
package neuron_pkg;

   localparam int POOL_SIZE = 128;
   localparam int IDX_W     = $clog2(POOL_SIZE);
   localparam int I_SCALE   = 1024;

   typedef logic signed [31:0] state_t;

   localparam state_t STATE_MAX = 32'sh7FFF_FFFF;
   localparam state_t STATE_MIN = 32'sh8000_0000;

   // Signed add evaluated at 34 bits, clamped to the 32-bit range.
   function automatic state_t sat_add(input state_t a, input state_t b);
      logic signed [33:0] s;
      s = {{2{a[31]}}, a} + {{2{b[31]}}, b};
      if (s[33:31] == 3'b000 || s[33:31] == 3'b111) begin
         return s[31:0];
      end
      return s[33] ? STATE_MIN : STATE_MAX;
   endfunction

endpackage

// File: rtl/neuron_state_ram.sv
// Single-port state memory: synchronous read, synchronous write, no reset.
// Ports: clk, addr, we, wdata in; rdata out (registered, read-before-write).
module neuron_state_ram #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int W     = 36
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/lif_neuron_pool.sv
// Time-multiplexed leaky integrate-and-fire population, one 2-cycle slot per neuron.
// Ports: clk, reset, I_in in; slot_index, phase, spike_out, spike_index,
//        v_mon, spike_count, frame_done out (all registered).
module lif_neuron_pool
   import neuron_pkg::*;
#(
   parameter int     N_NEURONS  = POOL_SIZE,
   parameter state_t V_THRESH   = state_t'(10 * I_SCALE),
   parameter state_t V_RESET    = '0,
   parameter int     LEAK_SHIFT = 3,
   parameter int     REFRACT    = 2,
   localparam int    IW         = $clog2(N_NEURONS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   I_in,
   output logic [IW-1:0] slot_index,
   output logic          phase,
   output logic          spike_out,
   output logic [IW-1:0] spike_index,
   output logic [31:0]   v_mon,
   output logic [7:0]    spike_count,
   output logic          frame_done
);

   localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);

   logic          phase_q, phase_d;
   logic [IW-1:0] slot_q, slot_d;
   logic          first_pass_q, first_pass_d;
   logic [7:0]    run_cnt_q, run_cnt_d;
   logic          spike_q, spike_d;
   logic [IW-1:0] spike_idx_q, spike_idx_d;
   state_t        v_mon_q, v_mon_d;
   logic [7:0]    spike_cnt_q, spike_cnt_d;
   logic          frame_done_q, frame_done_d;

   logic [35:0]   rd_data;
   logic [35:0]   wr_data;
   state_t        rd_v;
   logic [3:0]    rd_r;

   state_t        v_src;
   logic [3:0]    r_src;
   state_t        leak;
   state_t        sat_sum;
   state_t        v_next;
   logic [3:0]    r_next;
   logic          fire;
   logic [7:0]    cnt_inc;

   assign rd_v    = rd_data[31:0];
   assign rd_r    = rd_data[35:32];
   assign wr_data = {r_next, v_next};

   neuron_state_ram #(
      .DEPTH (N_NEURONS),
      .AW    (IW),
      .W     (36)
   ) u_state (
      .clk   (clk),
      .addr  (slot_q),
      .we    (phase_q),
      .wdata (wr_data),
      .rdata (rd_data)
   );

   // Neuron update; memory contents are ignored until one full pass is written.
   always_comb begin
      v_src   = first_pass_q ? V_RESET : rd_v;
      r_src   = first_pass_q ? 4'd0 : rd_r;
      leak    = v_src >>> LEAK_SHIFT;
      // v - (v >>> k) always fits in 32 bits, so only the current add can overflow.
      sat_sum = sat_add(v_src - leak, state_t'(I_in));
      fire    = 1'b0;
      v_next  = sat_sum;
      r_next  = 4'd0;
      if (r_src != 4'd0) begin
         v_next = V_RESET;
         r_next = r_src - 4'd1;
      end else if (sat_sum >= V_THRESH) begin
         fire   = 1'b1;
         v_next = V_RESET;
         r_next = 4'(REFRACT);
      end
   end

   always_comb begin
      phase_d      = ~phase_q;
      slot_d       = slot_q;
      first_pass_d = first_pass_q;
      run_cnt_d    = run_cnt_q;
      spike_d      = 1'b0;
      spike_idx_d  = spike_idx_q;
      v_mon_d      = v_mon_q;
      spike_cnt_d  = spike_cnt_q;
      frame_done_d = 1'b0;
      cnt_inc      = run_cnt_q;
      if (fire && run_cnt_q != 8'hFF) begin
         cnt_inc = run_cnt_q + 8'd1;
      end
      if (phase_q) begin
         slot_d      = (slot_q == LAST) ? '0 : slot_q + 1'b1;
         spike_d     = fire;
         spike_idx_d = slot_q;
         run_cnt_d   = cnt_inc;
         if (slot_q == '0) begin
            v_mon_d = v_next;
         end
         if (slot_q == LAST) begin
            frame_done_d = 1'b1;
            spike_cnt_d  = cnt_inc;
            run_cnt_d    = 8'd0;
            first_pass_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q      <= 1'b0;
         slot_q       <= '0;
         first_pass_q <= 1'b1;
         run_cnt_q    <= 8'd0;
         spike_q      <= 1'b0;
         spike_idx_q  <= '0;
         v_mon_q      <= '0;
         spike_cnt_q  <= 8'd0;
         frame_done_q <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         slot_q       <= slot_d;
         first_pass_q <= first_pass_d;
         run_cnt_q    <= run_cnt_d;
         spike_q      <= spike_d;
         spike_idx_q  <= spike_idx_d;
         v_mon_q      <= v_mon_d;
         spike_cnt_q  <= spike_cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign slot_index  = slot_q;
   assign phase       = phase_q;
   assign spike_out   = spike_q;
   assign spike_index = spike_idx_q;
   assign v_mon       = v_mon_q;
   assign spike_count = spike_cnt_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_lif_neuron_pool.sv
// Directed bench for lif_neuron_pool: zero input, ramp/refractory, saturation,
// and mid-pass reset, with hand-computed expected values.
module tb_lif_neuron_pool;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] I_in;
   logic [6:0]  slot_index;
   logic        phase;
   logic        spike_out;
   logic [6:0]  spike_index;
   logic [31:0] v_mon;
   logic [7:0]  spike_count;
   logic        frame_done;

   int checks = 0;
   int failures = 0;
   int mode = 0;
   int spikes_seen = 0;
   int last_spike_idx = -1;
   int frame_cyc = 0;

   int exp_v [10] = '{2048, 3840, 5408, 6780, 7981, 9032, 9951, 0, 0, 0};

   always #5 clk = ~clk;

   lif_neuron_pool dut (
      .clk         (clk),
      .reset       (reset),
      .I_in        (I_in),
      .slot_index  (slot_index),
      .phase       (phase),
      .spike_out   (spike_out),
      .spike_index (spike_index),
      .v_mon       (v_mon),
      .spike_count (spike_count),
      .frame_done  (frame_done)
   );

   // Upstream current for the slot currently shown on slot_index.
   always_comb begin
      I_in = 32'd0;
      case (mode)
         1: I_in = 32'd2048;
         2: if (slot_index == 7'd5) I_in = 32'h7FFF_FFFF;
         3: if (slot_index == 7'd0) I_in = 32'h8000_0000;
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      spikes_seen = 0;
      while (!seen && n < 600) begin
         @(negedge clk);
         n++;
         if (spike_out) begin
            spikes_seen++;
            last_spike_idx = int'(spike_index);
         end
         if (frame_done) seen = 1'b1;
      end
      frame_cyc = n;
      if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int n;
      #2 reset = 1'b1;
      @(negedge clk);
      chk("rst_slot", 32'(slot_index), 32'd0);
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_spike", 32'(spike_out), 32'd0);
      chk("rst_sidx", 32'(spike_index), 32'd0);
      chk("rst_vmon", v_mon, 32'd0);
      chk("rst_cnt", 32'(spike_count), 32'd0);
      chk("rst_fdone", 32'(frame_done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rel_phase0", 32'(phase), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_phase1", 32'(phase), 32'd1);
      chk("rel_slot0", 32'(slot_index), 32'd0);

      // Zero input: nothing integrates, frames every 256 cycles.
      mode = 0;
      for (int p = 0; p < 4; p++) begin
         wait_frame("zero");
         if (p > 0) chk($sformatf("zero_period_p%0d", p + 1), frame_cyc, 256);
         chk($sformatf("zero_v_p%0d", p + 1), v_mon, 32'd0);
         chk($sformatf("zero_cnt_p%0d", p + 1), 32'(spike_count), 32'd0);
         chk($sformatf("zero_spk_p%0d", p + 1), spikes_seen, 0);
      end

      // Constant 2048 ramp, spike on pass 8, refractory, repeat on pass 18.
      mode = 1;
      for (int p = 0; p < 18; p++) begin
         wait_frame("ramp");
         chk($sformatf("ramp_v_p%0d", p + 1), v_mon, 32'(exp_v[p % 10]));
         chk($sformatf("ramp_cnt_p%0d", p + 1), 32'(spike_count),
             (p % 10 == 7) ? 32'd128 : 32'd0);
         chk($sformatf("ramp_spk_p%0d", p + 1), spikes_seen,
             (p % 10 == 7) ? 128 : 0);
      end

      // Mid-pass reset at slot 60 of pass 3; stale memory must be ignored.
      do_reset();
      wait_frame("mid1");
      chk("mid_v_p1", v_mon, 32'd2048);
      wait_frame("mid2");
      chk("mid_v_p2", v_mon, 32'd3840);
      n = 0;
      while (slot_index != 7'd60 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("mid_slot60_found", 32'(slot_index), 32'd60);
      reset = 1'b1;
      #1;
      chk("mid_rst_slot", 32'(slot_index), 32'd0);
      chk("mid_rst_phase", 32'(phase), 32'd0);
      chk("mid_rst_vmon", v_mon, 32'd0);
      chk("mid_rst_cnt", 32'(spike_count), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rel_slot", 32'(slot_index), 32'd0);
      chk("mid_rel_phase", 32'(phase), 32'd0);
      wait_frame("mid3");
      chk("mid_first_pass_v", v_mon, 32'd2048);
      chk("mid_first_pass_cnt", 32'(spike_count), 32'd0);

      // Max positive current on slot 5 only: saturates high and fires.
      mode = 2;
      do_reset();
      wait_frame("hi");
      chk("hi_cnt", 32'(spike_count), 32'd1);
      chk("hi_pulses", spikes_seen, 1);
      chk("hi_idx", last_spike_idx, 5);
      chk("hi_vmon", v_mon, 32'd0);

      // Most negative current on slot 0: saturates low, never wraps.
      mode = 3;
      do_reset();
      wait_frame("lo1");
      chk("lo_v_p1", v_mon, 32'h8000_0000);
      chk("lo_cnt_p1", 32'(spike_count), 32'd0);
      chk("lo_spk_p1", spikes_seen, 0);
      wait_frame("lo2");
      chk("lo_v_p2", v_mon, 32'h8000_0000);
      chk("lo_cnt_p2", 32'(spike_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
